// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path: FSM states, parity modes,
// default timing values and the frame parity check.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [1:0] PS2_PAR_NONE = 2'd0;
    localparam logic [1:0] PS2_PAR_ODD  = 2'd1;
    localparam logic [1:0] PS2_PAR_EVEN = 2'd2;

    localparam int PS2_DEF_DATA_BITS   = 8;
    localparam int PS2_DEF_FIFO_DEPTH  = 4;
    localparam int PS2_DEF_TIMEOUT_CYC = 5000;
    localparam int PS2_DEF_FILTER_LEN  = 4;

    // xor_all is the XOR of every data bit and the received parity bit.
    function automatic logic ps2_parity_ok(input logic xor_all, input logic [1:0] mode);
        case (mode)
            PS2_PAR_ODD:  return xor_all;
            PS2_PAR_EVEN: return ~xor_all;
            default:      return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one PS/2 pin, idling high after reset.
// An optional glitch filter is enabled by defining PS2_RX_GLITCH_FILTER_EN.
module ps2_line_sync #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

`ifdef PS2_RX_GLITCH_FILTER_EN
    localparam bit FILTER_ON = 1'b1;
`else
    localparam bit FILTER_ON = 1'b0;
`endif

    localparam int EFF_LEN = FILTER_ON ? FILTER_LEN : 0;

    logic s1;
    logic s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    generate
        if (EFF_LEN > 0) begin : g_filter
            localparam int CW = $clog2(EFF_LEN + 1);
            logic [CW-1:0] cnt;
            logic          filt;

            // Output follows the line only after EFF_LEN consecutive differing samples.
            always_ff @(posedge clk) begin
                if (rst) begin
                    filt <= 1'b1;
                    cnt  <= '0;
                end else if (s2 == filt) begin
                    cnt <= '0;
                end else if (cnt == CW'(EFF_LEN - 1)) begin
                    filt <= s2;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign dout = filt;
        end else begin : g_bypass
            assign dout = s2;
        end
    endgenerate

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host frame receiver with first-word fall-through output FIFO.
// Define PS2_RX_GLITCH_FILTER_EN to add a glitch filter on both pins.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int DATA_BITS   = PS2_DEF_DATA_BITS,
    parameter int PARITY_MODE = 1,
    parameter int FIFO_DEPTH  = PS2_DEF_FIFO_DEPTH,
    parameter int TIMEOUT_CYC = PS2_DEF_TIMEOUT_CYC,
    parameter int FILTER_LEN  = PS2_DEF_FILTER_LEN
) (
    input  logic                          clk,
    input  logic                          RST,
    input  logic                          SCL,
    input  logic                          SDA,
    output logic [DATA_BITS-1:0]          data_out,
    output logic                          data_valid,
    input  logic                          data_ready,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [1:0] PMODE = 2'(PARITY_MODE);

    logic scl_s;
    logic sda_s;
    logic scl_prev;
    logic strobe;
    logic sda_q;

    ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_scl_sync (
        .clk  (clk),
        .rst  (RST),
        .din  (SCL),
        .dout (scl_s)
    );

    ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_sda_sync (
        .clk  (clk),
        .rst  (RST),
        .din  (SDA),
        .dout (sda_s)
    );

    // Strobe is registered so the FSM and the SDA sample it uses line up one cycle later.
    always_ff @(posedge clk) begin
        if (RST) begin
            scl_prev <= 1'b1;
            strobe   <= 1'b0;
            sda_q    <= 1'b1;
        end else begin
            scl_prev <= scl_s;
            strobe   <= scl_prev & ~scl_s;
            sda_q    <= sda_s;
        end
    end

    ps2_state_t            state;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_BITS-1:0]  shreg;
    logic                  par_bit;
    logic [TW-1:0]         tmo_cnt;
    logic                  timeout;
    logic                  push_req;

    assign timeout  = (state != ST_IDLE) && !strobe && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign push_req = strobe && (state == ST_STOP) && sda_q
                      && ps2_parity_ok(^shreg ^ par_bit, PMODE);

    always_ff @(posedge clk) begin
        if (RST) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            tmo_cnt    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;

            if (strobe || state == ST_IDLE) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (timeout) begin
                state     <= ST_IDLE;
                frame_err <= 1'b1;
            end else if (strobe) begin
                case (state)
                    ST_IDLE: begin
                        if (!sda_q) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        shreg   <= {sda_q, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BW'(DATA_BITS - 1)) begin
                            state <= (PMODE == PS2_PAR_NONE) ? ST_STOP : ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_bit <= sda_q;
                        state   <= ST_STOP;
                    end
                    default: begin
                        state <= ST_IDLE;
                        if (!sda_q) begin
                            frame_err <= 1'b1;
                        end else if (!push_req) begin
                            parity_err <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW-1:0]        next_rd;
    logic [LW-1:0]        count;
    logic [LW-1:0]        count_next;
    logic                 full;
    logic                 pop;
    logic                 push_ok;

    assign data_valid = (count != '0);
    assign fifo_level = count;
    assign full       = (count == LW'(FIFO_DEPTH));
    assign pop        = data_valid && data_ready;
    assign push_ok    = push_req && (!full || pop);

    always_comb begin
        next_rd    = pop ? rd_ptr + 1'b1 : rd_ptr;
        count_next = count + LW'(push_ok) - LW'(pop);
    end

    // data_out is registered: it is loaded with the word that will be at the head after this edge.
    always_ff @(posedge clk) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            overflow <= push_req && full && !pop;
            if (push_ok) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            rd_ptr <= next_rd;
            count  <= count_next;
            if (count_next != '0) begin
                data_out <= (push_ok && wr_ptr == next_rd) ? shreg : mem[next_rd];
            end
        end
    end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver running entirely in the system `clk` domain. It oversamples the asynchronous `SCL`/`SDA` lines, decodes start/data/parity/stop frames of configurable width and parity mode, and detects parity, framing and timeout errors. Good frames are buffered in an internal FIFO with a valid/ready output handshake. It sits between the keyboard/mouse pins and the scan-code decoder.

## Interface

Parameters:
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `PARITY_MODE`, 1: 0 = none, 1 = odd, 2 = even.
- `FIFO_DEPTH`, 4: FIFO entries; power of two, at least 2.
- `TIMEOUT_CYC`, 5000: `clk` cycles allowed between consecutive SCL falling edges inside a frame.
- `FILTER_LEN`, 4: stable samples required by the glitch filter (see Configuration).

Ports:
- `clk`  in  1  system clock.
- `RST`  in  1  synchronous, active-high reset.
- `SCL`  in  1  PS/2 clock pin, asynchronous.
- `SDA`  in  1  PS/2 data pin, asynchronous.
- `data_out`  out  DATA_BITS  FIFO head word, LSB = first data bit received.
- `data_valid`  out  1  FIFO not empty.
- `data_ready`  in  1  consumer accepts the head word.
- `parity_err`  out  1  one-cycle pulse: frame dropped, parity mismatch.
- `frame_err`  out  1  one-cycle pulse: frame dropped, stop bit 0 or timeout.
- `overflow`  out  1  one-cycle pulse: good frame dropped because the FIFO was full.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of words stored.

## Operation

- `SCL` and `SDA` each pass through a 2-flop synchroniser. A falling-edge strobe is raised when the registered previous `SCL` is 1 and the current `SCL` is 0. `SDA` is sampled on the strobe.
- FSM states:
  - IDLE: strobe with `SDA`=0 → DATA, bit count cleared. Strobe with `SDA`=1 is ignored.
  - DATA: each strobe shifts `SDA` into the MSB of a right-shifting register. After `DATA_BITS` strobes → PARITY, or → STOP when `PARITY_MODE`=0.
  - PARITY: one strobe captures the parity bit → STOP.
  - STOP: on strobe, always → IDLE, with one of these outcomes:
    - `SDA`=0 → `frame_err`.
    - `SDA`=1 and parity mismatch → `parity_err`.
    - `SDA`=1 and parity correct → push.
- Parity rules:
  - Odd: XOR of data and parity bits = 1.
  - Even: XOR of data and parity bits = 0.
- Timeout: a counter clears on every strobe and counts while the FSM is not in IDLE. Reaching `TIMEOUT_CYC` raises `frame_err`, sends the FSM to IDLE and discards the partial frame.
- FIFO is first-word fall-through:
  - `data_out` shows the head word whenever `data_valid`=1.
  - Pop occurs on `data_valid` & `data_ready`.
- Push when full:
  - If a pop happens in the same cycle, the push is accepted and `overflow` is not raised.
  - Otherwise the new word is dropped and `overflow` pulses.
- `data_out` holds its last value when empty; its value is don't-care while `data_valid`=0.
- Reset values (`RST` sampled 1 at a `clk` edge, including mid-frame or mid-handshake):
  - FSM returns to IDLE; counters and pointers cleared.
  - All outputs 0.
  - Synchroniser flops load 1 (idle bus), so no false strobe follows reset.

## Timing

- Edge E = first `clk` edge that samples a pin low into synchroniser stage 1. The strobe is high in the cycle after edge E+2.
- Push and error pulses register on edge E+3.
- `data_valid`, `fifo_level` and the error outputs change at E+3. Latency from the stop-bit falling edge to `data_valid` is 3 `clk` edges, plus `FILTER_LEN` edges with the filter enabled.
- Pop is registered:
  - `fifo_level` decrements on the edge where `data_valid` & `data_ready`.
  - The next head word appears in the following cycle.
- Error pulses are exactly one cycle wide. At most one of `parity_err`, `frame_err`, `overflow` fires per frame.
- The PS/2 bit period (60–100 µs) must be at least 8 `clk` cycles. `TIMEOUT_CYC` must exceed one bit period.

## Configuration

- `PS2_RX_GLITCH_FILTER_EN`:
  - Defined: a filter after each synchroniser changes its output only after `FILTER_LEN` consecutive identical samples. Pulses shorter than `FILTER_LEN` cycles are ignored. Latency grows by `FILTER_LEN` cycles.
  - Undefined: the synchroniser output feeds edge detection directly, with no added latency.

## Structure

- Package `ps2_pkg`:
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - Parity-mode constants: `PS2_PAR_NONE`, `PS2_PAR_ODD`, `PS2_PAR_EVEN`.
  - Default timing constants.
- Sub-module `ps2_line_sync`: 2-flop synchroniser plus the optional glitch filter, instantiated once for `SCL` and once for `SDA`.
- FIFO storage and pointers stay inline.

## Test plan

- Default params, frame 0x1C with parity 0 and stop 1 → `data_valid` 3 edges after the stop edge, `data_out`=0x1C. With `data_ready`=1 the FIFO is popped, `fifo_level` back to 0.
- Frame 0x1C with parity 1 → one-cycle `parity_err` pulse, `data_valid` stays 0. Then 0xF0 with parity 1 → received correctly.
- Frame 0xAA with stop bit 0 → `frame_err` pulse, nothing pushed.
- Stop `SCL` after 4 data bits and hold for `TIMEOUT_CYC` cycles → `frame_err` pulse, FSM in IDLE. Then a clean 0x55 frame is received correctly.
- `data_ready`=0, frames 0x01..0x05 → `fifo_level`=4, `overflow` pulse on the 5th frame. Draining yields 0x01, 0x02, 0x03, 0x04.
- Assert `RST` for one cycle after 5 data bits, then send 0x3C → no error pulse, 0x3C received. `DATA_BITS`=7, `PARITY_MODE`=2 variant: 0x7F with parity 1 → accepted.
